// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt controller: FSM states,
// vector layout defaults and the service-address helper.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    localparam int          MAX_NUM_IRQ        = 16;
    localparam logic [15:0] DEFAULT_VEC_BASE   = 16'h0040;
    localparam logic [15:0] DEFAULT_VEC_STRIDE = 16'h0004;

    // Service address wraps modulo 2^16, matching the core's address width.
    function automatic logic [15:0] vector_addr(input logic [15:0] base,
                                                input logic [15:0] stride,
                                                input logic [3:0]  idx);
        return base + (16'(idx) * stride);
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Bus between the CPU/peripheral side (master) and the interrupt
// controller (slave): raw request lines, mask/enable/ack/eoi, and grant info.
interface irq_controller_if #(
    parameter int NUM_IRQ = 4
);
    localparam int IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] irq;
    logic               mask_we;
    logic [NUM_IRQ-1:0] mask_wdata;
    logic               int_en;
    logic               int_ack;
    logic               eoi;

    logic               int_req;
    logic [IDW-1:0]     int_id;
    logic [15:0]        int_vector;
    logic               in_service;
    logic [NUM_IRQ-1:0] pending;

    modport master (
        output irq, mask_we, mask_wdata, int_en, int_ack, eoi,
        input  int_req, int_id, int_vector, in_service, pending
    );

    modport slave (
        input  irq, mask_we, mask_wdata, int_en, int_ack, eoi,
        output int_req, int_id, int_vector, in_service, pending
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any bit is set and the index of
// the lowest set bit (line 0 has the highest priority).
module irq_prio_enc #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  vec,
    output logic          valid,
    output logic [IW-1:0] index
);

    // Scan downward so the last hit, and therefore the winner, is the lowest index.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                valid = 1'b1;
                index = IW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Fixed-priority, non-nesting interrupt controller for the 16-bit core.
// Define IRQ_SYNC_EN to add a 2-flop synchronizer on every irq line.
module irq_controller
    import irq_pkg::*;
#(
    parameter int          NUM_IRQ    = 4,
    parameter logic [15:0] VEC_BASE   = DEFAULT_VEC_BASE,
    parameter logic [15:0] VEC_STRIDE = DEFAULT_VEC_STRIDE
) (
    input  logic            clk,
    input  logic            reset,
    irq_controller_if.slave bus
);

    localparam int IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] prev;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] arb_vec;
    logic               arb_valid;
    logic [IDW-1:0]     arb_index;

    irq_state_t         state;
    logic               int_req_q;
    logic               in_service_q;
    logic [IDW-1:0]     int_id_q;
    logic [15:0]        int_vector_q;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1;
    logic [NUM_IRQ-1:0] sync2;

    // Synchronizer resets high so a line already asserted never looks like a rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= bus.irq;
            sync2 <= sync1;
        end
    end

    assign irq_s = sync2;
`else
    assign irq_s = bus.irq;
`endif

    assign rise    = irq_s & ~prev;
    assign arb_vec = pending_q & mask;

    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr[i] = (state == REQ) && bus.int_ack && (int_id_q == IDW'(i));
        end
    end

    // A new rise on the same cycle as its ack clear keeps the bit set.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev      <= '1;
            pending_q <= '0;
            mask      <= '1;
        end else begin
            prev      <= irq_s;
            pending_q <= (pending_q & ~clr) | rise;
            if (bus.mask_we) begin
                mask <= bus.mask_wdata;
            end
        end
    end

    irq_prio_enc #(
        .N  (NUM_IRQ),
        .IW (IDW)
    ) u_prio_enc (
        .vec   (arb_vec),
        .valid (arb_valid),
        .index (arb_index)
    );

    // Grant is latched on entry to REQ and held until the next grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            int_req_q    <= 1'b0;
            in_service_q <= 1'b0;
            int_id_q     <= '0;
            int_vector_q <= VEC_BASE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.int_en && arb_valid) begin
                        state        <= REQ;
                        int_req_q    <= 1'b1;
                        int_id_q     <= arb_index;
                        int_vector_q <= vector_addr(VEC_BASE, VEC_STRIDE, 4'(arb_index));
                    end
                end
                REQ: begin
                    if (bus.int_ack) begin
                        state        <= SERVICE;
                        int_req_q    <= 1'b0;
                        in_service_q <= 1'b1;
                    end
                end
                SERVICE: begin
                    if (bus.eoi) begin
                        state        <= IDLE;
                        in_service_q <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    int_req_q    <= 1'b0;
                    in_service_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.int_req    = int_req_q;
    assign bus.in_service = in_service_q;
    assign bus.int_id     = int_id_q;
    assign bus.int_vector = int_vector_q;
    assign bus.pending    = pending_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed testbench for irq_controller (NUM_IRQ = 4, default vectors).
// Request latency follows IRQ_SYNC_EN when the bench is built with it.
module tb_irq_controller;

`ifdef IRQ_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    irq_controller_if #(.NUM_IRQ(4)) ifc ();

    irq_controller #(
        .NUM_IRQ    (4),
        .VEC_BASE   (16'h0040),
        .VEC_STRIDE (16'h0004)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the next rising edge sample them,
    // then settle 1 time unit past the edge so outputs can be inspected.
    task automatic applyStimulus(input logic [3:0] irq_i,
                                 input logic       en_i,
                                 input logic       ack_i,
                                 input logic       eoi_i,
                                 input logic       mwe_i,
                                 input logic [3:0] mdata_i);
        ifc.irq        = irq_i;
        ifc.int_en     = en_i;
        ifc.int_ack    = ack_i;
        ifc.eoi        = eoi_i;
        ifc.mask_we    = mwe_i;
        ifc.mask_wdata = mdata_i;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b1;
        ifc.irq        = '0;
        ifc.int_en     = 1'b0;
        ifc.int_ack    = 1'b0;
        ifc.eoi        = 1'b0;
        ifc.mask_we    = 1'b0;
        ifc.mask_wdata = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        checkOutput("rst int_req", 32'(ifc.int_req), 32'd0);
        checkOutput("rst in_service", 32'(ifc.in_service), 32'd0);
        checkOutput("rst pending", 32'(ifc.pending), 32'h0);
        checkOutput("rst int_id", 32'(ifc.int_id), 32'd0);
        checkOutput("rst int_vector", 32'(ifc.int_vector), 32'h0040);
        reset = 1'b0;
        idle(2);

        $display("[TB] single request");
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        idle(LAT - 2);
        checkOutput("t1 req early", 32'(ifc.int_req), 32'd0);
        checkOutput("t1 pending set", 32'(ifc.pending), 32'h4);
        idle(1);
        checkOutput("t1 req", 32'(ifc.int_req), 32'd1);
        checkOutput("t1 id", 32'(ifc.int_id), 32'd2);
        checkOutput("t1 vector", 32'(ifc.int_vector), 32'h0048);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("t1 ack req", 32'(ifc.int_req), 32'd0);
        checkOutput("t1 ack service", 32'(ifc.in_service), 32'd1);
        checkOutput("t1 ack pending", 32'(ifc.pending), 32'h0);
        idle(1);
        checkOutput("t1 service hold", 32'(ifc.in_service), 32'd1);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
        checkOutput("t1 eoi service", 32'(ifc.in_service), 32'd0);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("t1 stray ack", 32'(ifc.in_service), 32'd0);
        checkOutput("t1 idle id hold", 32'(ifc.int_id), 32'd2);

        $display("[TB] priority");
        applyStimulus(4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        idle(LAT - 1);
        checkOutput("t2 req", 32'(ifc.int_req), 32'd1);
        checkOutput("t2 id first", 32'(ifc.int_id), 32'd1);
        checkOutput("t2 vector first", 32'(ifc.int_vector), 32'h0044);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
        checkOutput("t2 stray eoi", 32'(ifc.int_req), 32'd1);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("t2 pending after ack", 32'(ifc.pending), 32'h8);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
        checkOutput("t2 gap", 32'(ifc.int_req), 32'd0);
        idle(1);
        checkOutput("t2 req second", 32'(ifc.int_req), 32'd1);
        checkOutput("t2 id second", 32'(ifc.int_id), 32'd3);
        checkOutput("t2 vector second", 32'(ifc.int_vector), 32'h004C);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);

        $display("[TB] masking and global enable");
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1110);
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        idle(LAT + 1);
        checkOutput("t3 masked req", 32'(ifc.int_req), 32'd0);
        checkOutput("t3 masked pending", 32'(ifc.pending), 32'h1);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1111);
        checkOutput("t3 write edge req", 32'(ifc.int_req), 32'd0);
        idle(1);
        checkOutput("t3 unmask req", 32'(ifc.int_req), 32'd1);
        checkOutput("t3 unmask id", 32'(ifc.int_id), 32'd0);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);

        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < LAT + 1; i++) applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        checkOutput("t3 disabled req", 32'(ifc.int_req), 32'd0);
        checkOutput("t3 disabled pending", 32'(ifc.pending), 32'h4);
        idle(1);
        checkOutput("t3 enable req", 32'(ifc.int_req), 32'd1);
        checkOutput("t3 enable id", 32'(ifc.int_id), 32'd2);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < LAT; i++) applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        checkOutput("t3 req held", 32'(ifc.int_req), 32'd1);
        checkOutput("t3 id held", 32'(ifc.int_id), 32'd2);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1111);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
        idle(1);
        checkOutput("t3 late line0", 32'(ifc.int_id), 32'd0);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);

        $display("[TB] no nesting and set-wins");
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        idle(LAT - 1);
        checkOutput("t4 req line0", 32'(ifc.int_id), 32'd0);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        idle(LAT + 1);
        checkOutput("t4 no nest req", 32'(ifc.int_req), 32'd0);
        checkOutput("t4 no nest service", 32'(ifc.in_service), 32'd1);
        checkOutput("t4 no nest pending", 32'(ifc.pending), 32'h5);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
        idle(1);
        checkOutput("t4 regrant req", 32'(ifc.int_req), 32'd1);
        checkOutput("t4 regrant id", 32'(ifc.int_id), 32'd0);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("t4 pending left", 32'(ifc.pending), 32'h4);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
        idle(1);
        checkOutput("t4 grant line2", 32'(ifc.int_id), 32'd2);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
        applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        idle(LAT - 1);
        checkOutput("t4 grant line1", 32'(ifc.int_id), 32'd1);
        applyStimulus(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("t4 setwin service", 32'(ifc.in_service), 32'd1);
        idle(LAT - 2);
        checkOutput("t4 setwin pending", 32'(ifc.pending), 32'h2);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
        idle(1);
        checkOutput("t4 setwin regrant", 32'(ifc.int_id), 32'd1);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < LAT; i++) applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        checkOutput("t5 req before reset", 32'(ifc.int_req), 32'd1);
        reset = 1'b1;
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        reset = 1'b0;
        checkOutput("t5 reset req", 32'(ifc.int_req), 32'd0);
        checkOutput("t5 reset pending", 32'(ifc.pending), 32'h0);
        for (int i = 0; i < LAT + 3; i++) applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        checkOutput("t5 held line req", 32'(ifc.int_req), 32'd0);
        checkOutput("t5 held line pending", 32'(ifc.pending), 32'h0);
        checkOutput("t5 vector reset", 32'(ifc.int_vector), 32'h0040);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
